// File: rtl/pattern_detect_param.sv
// ============================================================================
// Module   : pattern_detect_param
// Brief    : Serial pattern detector with a runtime-programmable pattern of
//            LEN bits and a per-bit don't-care mask. Overlapping matches are
//            chosen at elaboration. A sample qualifier (en) lets the stream
//            contain gaps. Outputs are a Mealy match flag (y), a registered
//            copy of it (hit) and an optional saturating match counter.
// Options  : define PATTERN_DETECT_COUNT_EN to add the match_cnt port and
//            the counter logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_detect_param #(
    parameter int LEN     = 4,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic [LEN-1:0]   pattern,
    input  logic [LEN-1:0]   mask,
    input  logic             clr,
    output logic             y,
    output logic             hit
`ifdef PATTERN_DETECT_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    // The fill counter only has to reach LEN-1, so clog2(LEN) bits suffice.
    localparam int                  c_FILL_W   = $clog2(LEN);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(LEN - 1);
    localparam logic [c_FILL_W-1:0] c_FILL_ONE = c_FILL_W'(1);

    // Elaboration-time range guard; the block only exists for illegal values.
    generate
        if (LEN < 2 || LEN > 16 || CNT_W < 1) begin : g_param_range_error
        end
    endgenerate

    logic [LEN-2:0]      r_hist;
    logic [c_FILL_W-1:0] r_fill;
    logic                r_hit;
    logic [LEN-1:0]      w_window;
    logic                w_full;
    logic                w_cmp;
    logic                w_y;

    // The window is the stored history plus the bit on the wire this cycle,
    // so a match is flagged in the same cycle as its final bit.
    assign w_window = {r_hist, x};
    assign w_full   = (r_fill == c_FILL_MAX);
    assign w_cmp    = (((w_window ^ pattern) & mask) == '0);

    // Reset, clear and idle cycles can never produce a match.
    assign w_y = rst & en & ~clr & w_full & w_cmp;

    // History shift register and saturating fill count; held while en=0.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (en) begin
            // Dropping the oldest window bit is the history shift.
            r_hist <= w_window[LEN-2:0];
            if (w_y && (OVERLAP == 0)) begin
                // Non-overlapping: the next match needs LEN fresh bits.
                r_fill <= '0;
            end else if (!w_full) begin
                r_fill <= r_fill + c_FILL_ONE;
            end
        end
    end

    // Registered copy of the match flag; clr reaches it only through y.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= w_y;
        end
    end

    assign y   = w_y;
    assign hit = r_hit;

`ifdef PATTERN_DETECT_COUNT_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Saturating match counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_cnt <= '0;
        end else if (w_y && (r_cnt != '1)) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    assign match_cnt = r_cnt;
`endif

endmodule

`default_nettype wire
